// File: rtl/data_sram_like_bridge_if.sv
// Sram-like data bus between the data bridge (master) and the memory side (slave).
// A request is accepted on mem_req & mem_addr_ok; mem_data_ok marks completion.
interface data_sram_like_bridge_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          mem_req;
    logic          mem_wr;
    logic [1:0]    mem_size;
    logic [3:0]    mem_wstrb;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_addr_ok;
    logic          mem_data_ok;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/data_sram_like_bridge.sv
// Converts the core's single-cycle data-SRAM access into one sram-like bus transaction,
// stalling the pipeline until the bus reports completion.
module data_sram_like_bridge #(
    parameter int          AW      = 32,
    parameter int          DW      = 32,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          cpu_en,
    input  logic [3:0]    cpu_wen,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          stallreq,
    output logic          err_timeout,
    data_sram_like_bridge_if.master mem
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t        state_reg;
    logic          req_reg;
    logic          wr_reg;
    logic [1:0]    size_reg;
    logic [3:0]    wen_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] wdata_reg;
    logic [DW-1:0] rdata_reg;
    logic          err_reg;
    logic [CW-1:0] wait_cnt_reg;
    logic [CW-1:0] wait_cnt_next;

    // Single-lane strobes are bytes, aligned lane pairs are halves; everything else is a word.
    function automatic logic [1:0] size_of(input logic [3:0] wen);
        logic [1:0] sz;
        case (wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: sz = 2'd0;
            4'b0011, 4'b1100:                   sz = 2'd1;
            default:                            sz = 2'd2;
        endcase
        return sz;
    endfunction

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (wait_cnt_reg != CNT_MAX) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= ST_IDLE;
            req_reg      <= 1'b0;
            wr_reg       <= 1'b0;
            size_reg     <= 2'd0;
            wen_reg      <= 4'd0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            rdata_reg    <= '0;
            err_reg      <= 1'b0;
            wait_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // Any data_ok arriving here belongs to an abandoned transaction.
                    if (cpu_en) begin
                        wen_reg   <= cpu_wen;
                        addr_reg  <= cpu_addr;
                        wdata_reg <= cpu_wdata;
                        size_reg  <= size_of(cpu_wen);
                        wr_reg    <= |cpu_wen;
                        req_reg   <= 1'b1;
                        state_reg <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem.mem_addr_ok) begin
                        req_reg      <= 1'b0;
                        wait_cnt_reg <= '0;
                        state_reg    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem.mem_data_ok) begin
                        if (!wr_reg) begin
                            rdata_reg <= mem.mem_rdata;
                        end
                        state_reg <= ST_DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_next;
                        if ((TIMEOUT != 0) && (wait_cnt_next == CNT_MAX)) begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // Pipeline advances this cycle; the next access starts from IDLE.
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // The IDLE term must be combinational so the stall lands in the same cycle as cpu_en.
    assign stallreq = ((state_reg == ST_IDLE) && cpu_en) ||
                      (state_reg == ST_REQ) || (state_reg == ST_WAIT);

    assign cpu_rdata     = rdata_reg;
    assign err_timeout   = err_reg;
    assign mem.mem_req   = req_reg;
    assign mem.mem_wr    = wr_reg;
    assign mem.mem_size  = size_reg;
    assign mem.mem_wstrb = wen_reg;
    assign mem.mem_addr  = addr_reg;
    assign mem.mem_wdata = wdata_reg;

endmodule

// File: tb/tb_data_sram_like_bridge.sv
// Directed bench for data_sram_like_bridge: the bench plays the bus slave and the core.
module tb_data_sram_like_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stallreq;
    logic        err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    data_sram_like_bridge_if #(.AW(32), .DW(32)) bus ();

    data_sram_like_bridge #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cpu_en      (cpu_en),
        .cpu_wen     (cpu_wen),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .stallreq    (stallreq),
        .err_timeout (err_timeout),
        .mem         (bus.master)
    );

    always #5 clk = ~clk;

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Zero-wait access from IDLE; returns the request fields seen on the bus.
    task automatic do_access(input logic [3:0] wen, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rd,
                             output logic [1:0] sz, output logic wr, output logic [3:0] strb);
        next_cyc();
        cpu_en = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
        next_cyc();
        bus.mem_addr_ok = 1'b1;
        smp();
        sz = bus.mem_size; wr = bus.mem_wr; strb = bus.mem_wstrb;
        next_cyc();
        bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b1; bus.mem_rdata = rd;
        next_cyc();
        bus.mem_data_ok = 1'b0; bus.mem_rdata = '0;
        next_cyc();
        cpu_en = 1'b0;
        $display("txn wen=%b addr=%h wdata=%h size=%0d wr=%0b strb=%b", wen, addr, wdata, sz, wr, strb);
    endtask

    task automatic test_reset();
        resetn = 1'b0; cpu_en = 1'b0; cpu_wen = '0; cpu_addr = '0; cpu_wdata = '0;
        bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0; bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        smp();
        n_checks++; if (stallreq !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stallreq); end
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", bus.mem_req); end
        n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", cpu_rdata); end
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_timeout); end
        n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.mem_addr); end
        next_cyc();
        resetn = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_load();
        int stall_cycles = 0;
        next_cyc();
        cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h1000; cpu_wdata = '0;
        smp(); stall_cycles += int'(stallreq);
        n_checks++; if (stallreq !== 1'b1) begin n_fail++; $display("FAIL load_idle_stall: got %b want 1", stallreq); end
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL load_idle_req: got %b want 0", bus.mem_req); end
        next_cyc();
        bus.mem_addr_ok = 1'b1;
        smp(); stall_cycles += int'(stallreq);
        n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL load_req: got %b want 1", bus.mem_req); end
        n_checks++; if (bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL load_wr: got %b want 0", bus.mem_wr); end
        n_checks++; if (bus.mem_size !== 2'd2) begin n_fail++; $display("FAIL load_size: got %0d want 2", bus.mem_size); end
        n_checks++; if (bus.mem_addr !== 32'h1000) begin n_fail++; $display("FAIL load_addr: got %h want 00001000", bus.mem_addr); end
        next_cyc();
        bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        smp(); stall_cycles += int'(stallreq);
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL load_wait_req: got %b want 0", bus.mem_req); end
        next_cyc();
        bus.mem_data_ok = 1'b0; bus.mem_rdata = '0;
        smp(); stall_cycles += int'(stallreq);
        n_checks++; if (stallreq !== 1'b0) begin n_fail++; $display("FAIL load_done_stall: got %b want 0", stallreq); end
        n_checks++; if (cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_done_rdata: got %h want deadbeef", cpu_rdata); end
        n_checks++; if (stall_cycles != 3) begin n_fail++; $display("FAIL load_stall_len: got %0d want 3", stall_cycles); end
        next_cyc();
        cpu_en = 1'b0;
        smp();
        n_checks++; if (cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rdata_hold: got %h want deadbeef", cpu_rdata); end
        $display("txn load addr=00001000 rdata=%h", cpu_rdata);
    endtask

    task automatic test_store_byte();
        next_cyc();
        cpu_en = 1'b1; cpu_wen = 4'b0100; cpu_addr = 32'h2002; cpu_wdata = 32'h00AB0000;
        next_cyc();
        bus.mem_addr_ok = 1'b1;
        smp();
        n_checks++; if (bus.mem_wr !== 1'b1) begin n_fail++; $display("FAIL store_wr: got %b want 1", bus.mem_wr); end
        n_checks++; if (bus.mem_size !== 2'd0) begin n_fail++; $display("FAIL store_size: got %0d want 0", bus.mem_size); end
        n_checks++; if (bus.mem_wstrb !== 4'b0100) begin n_fail++; $display("FAIL store_strb: got %b want 0100", bus.mem_wstrb); end
        n_checks++; if (bus.mem_addr !== 32'h2002) begin n_fail++; $display("FAIL store_addr: got %h want 00002002", bus.mem_addr); end
        n_checks++; if (bus.mem_wdata !== 32'h00AB0000) begin n_fail++; $display("FAIL store_wdata: got %h want 00ab0000", bus.mem_wdata); end
        next_cyc();
        bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h12345678;
        next_cyc();
        bus.mem_data_ok = 1'b0; bus.mem_rdata = '0;
        smp();
        n_checks++; if (stallreq !== 1'b0) begin n_fail++; $display("FAIL store_done_stall: got %b want 0", stallreq); end
        n_checks++; if (cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL store_rdata_kept: got %h want deadbeef", cpu_rdata); end
        next_cyc();
        cpu_en = 1'b0;
        $display("txn store byte addr=00002002 wdata=00ab0000");
    endtask

    task automatic test_addr_ok_delay();
        int accepts = 0;
        next_cyc();
        cpu_en = 1'b1; cpu_wen = 4'b1100; cpu_addr = 32'h3000; cpu_wdata = 32'hCAFE0000;
        next_cyc();
        for (int i = 0; i < 6; i++) begin
            bus.mem_addr_ok = (i == 5);
            smp();
            if (bus.mem_req && bus.mem_addr_ok) accepts++;
            n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL delay_req[%0d]: got %b want 1", i, bus.mem_req); end
            n_checks++; if (bus.mem_addr !== 32'h3000 || bus.mem_wdata !== 32'hCAFE0000 || bus.mem_size !== 2'd1)
                begin n_fail++; $display("FAIL delay_fields[%0d]: got %h/%h/%0d want 00003000/cafe0000/1", i, bus.mem_addr, bus.mem_wdata, bus.mem_size); end
            next_cyc();
        end
        bus.mem_addr_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp();
            if (bus.mem_req && bus.mem_addr_ok) accepts++;
            n_checks++; if (bus.mem_req !== 1'b0 || stallreq !== 1'b1)
                begin n_fail++; $display("FAIL delay_wait[%0d]: got req=%b stall=%b want req=0 stall=1", i, bus.mem_req, stallreq); end
            next_cyc();
        end
        bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h00000055;
        next_cyc();
        bus.mem_data_ok = 1'b0; bus.mem_rdata = '0;
        smp();
        n_checks++; if (accepts != 1) begin n_fail++; $display("FAIL delay_accepts: got %0d want 1", accepts); end
        n_checks++; if (stallreq !== 1'b0) begin n_fail++; $display("FAIL delay_done_stall: got %b want 0", stallreq); end
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL delay_no_timeout: got %b want 0", err_timeout); end
        n_checks++; if (cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL delay_rdata_kept: got %h want deadbeef", cpu_rdata); end
        next_cyc();
        cpu_en = 1'b0;
        $display("txn store half addr=00003000 after 5-cycle addr_ok delay");
    endtask

    task automatic test_back_to_back();
        next_cyc();
        cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h4000;
        next_cyc();
        bus.mem_addr_ok = 1'b1;
        next_cyc();
        bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h11111111;
        next_cyc();
        bus.mem_data_ok = 1'b0; bus.mem_rdata = '0;
        smp();
        n_checks++; if (bus.mem_req !== 1'b0 || stallreq !== 1'b0)
            begin n_fail++; $display("FAIL b2b_done: got req=%b stall=%b want 0/0", bus.mem_req, stallreq); end
        $display("txn load addr=00004000 rdata=%h", cpu_rdata);
        next_cyc();
        cpu_addr = 32'h4004;
        smp();
        n_checks++; if (stallreq !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_stall: got %b want 1", stallreq); end
        n_checks++; if (cpu_rdata !== 32'h11111111) begin n_fail++; $display("FAIL b2b_rdata_valid: got %h want 11111111", cpu_rdata); end
        next_cyc();
        bus.mem_addr_ok = 1'b1;
        smp();
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h4004)
            begin n_fail++; $display("FAIL b2b_second_req: got req=%b addr=%h want 1/00004004", bus.mem_req, bus.mem_addr); end
        next_cyc();
        bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h22222222;
        next_cyc();
        bus.mem_data_ok = 1'b0; bus.mem_rdata = '0;
        smp();
        n_checks++; if (cpu_rdata !== 32'h22222222) begin n_fail++; $display("FAIL b2b_second_rdata: got %h want 22222222", cpu_rdata); end
        next_cyc();
        cpu_en = 1'b0;
        $display("txn load addr=00004004 rdata=%h", cpu_rdata);
    endtask

    task automatic test_size_decode();
        logic [3:0] wen_tab  [7] = '{4'b0001, 4'b0010, 4'b1000, 4'b0011, 4'b1111, 4'b0101, 4'b0000};
        logic [1:0] size_tab [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2};
        logic       wr_tab   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] sz;
        logic       wr;
        logic [3:0] strb;
        for (int i = 0; i < 7; i++) begin
            do_access(wen_tab[i], 32'h8000 + 32'(i * 4), 32'hA5A5_0000 + 32'(i), 32'h0BAD_0000 + 32'(i), sz, wr, strb);
            n_checks++; if (sz !== size_tab[i]) begin n_fail++; $display("FAIL size_decode[%b]: got %0d want %0d", wen_tab[i], sz, size_tab[i]); end
            n_checks++; if (wr !== wr_tab[i]) begin n_fail++; $display("FAIL wr_decode[%b]: got %b want %b", wen_tab[i], wr, wr_tab[i]); end
            n_checks++; if (strb !== wen_tab[i]) begin n_fail++; $display("FAIL strb_pass[%b]: got %b", wen_tab[i], strb); end
        end
        n_checks++; if (cpu_rdata !== 32'h0BAD0006) begin n_fail++; $display("FAIL size_load_rdata: got %h want 0bad0006", cpu_rdata); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] sz;
        logic       wr;
        logic [3:0] strb;
        next_cyc();
        cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h5000;
        next_cyc();
        bus.mem_addr_ok = 1'b1;
        next_cyc();
        bus.mem_addr_ok = 1'b0;
        smp();
        n_checks++; if (stallreq !== 1'b1) begin n_fail++; $display("FAIL rstmid_wait_stall: got %b want 1", stallreq); end
        #1;
        resetn = 1'b0; cpu_en = 1'b0;
        #1;
        n_checks++; if (stallreq !== 1'b0 || bus.mem_req !== 1'b0)
            begin n_fail++; $display("FAIL rstmid_async: got stall=%b req=%b want 0/0", stallreq, bus.mem_req); end
        n_checks++; if (cpu_rdata !== 32'h0 || bus.mem_addr !== 32'h0 || err_timeout !== 1'b0)
            begin n_fail++; $display("FAIL rstmid_clear: got rdata=%h addr=%h err=%b want 0/0/0", cpu_rdata, bus.mem_addr, err_timeout); end
        next_cyc();
        resetn = 1'b1;
        bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'hBADBAD00;
        for (int i = 0; i < 2; i++) begin
            smp();
            n_checks++; if (cpu_rdata !== 32'h0 || stallreq !== 1'b0 || bus.mem_req !== 1'b0)
                begin n_fail++; $display("FAIL rstmid_stray[%0d]: got rdata=%h stall=%b req=%b want 0/0/0", i, cpu_rdata, stallreq, bus.mem_req); end
            next_cyc();
        end
        bus.mem_data_ok = 1'b0; bus.mem_rdata = '0;
        $display("txn reset during WAIT, stray data_ok ignored");
        do_access(4'b0000, 32'h6000, 32'h0, 32'h600D600D, sz, wr, strb);
        n_checks++; if (cpu_rdata !== 32'h600D600D) begin n_fail++; $display("FAIL rstmid_recover: got %h want 600d600d", cpu_rdata); end
    endtask

    task automatic test_timeout();
        next_cyc();
        cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h7000;
        next_cyc();
        bus.mem_addr_ok = 1'b1;
        next_cyc();
        bus.mem_addr_ok = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            smp();
            n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_early[%0d]: got %b want 0", k, err_timeout); end
            next_cyc();
        end
        smp();
        n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_set: got %b want 1", err_timeout); end
        n_checks++; if (stallreq !== 1'b1) begin n_fail++; $display("FAIL timeout_stall: got %b want 1", stallreq); end
        next_cyc();
        smp();
        n_checks++; if (err_timeout !== 1'b1 || stallreq !== 1'b1 || bus.mem_req !== 1'b0)
            begin n_fail++; $display("FAIL timeout_keep_wait: got err=%b stall=%b req=%b want 1/1/0", err_timeout, stallreq, bus.mem_req); end
        bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h00000077;
        next_cyc();
        bus.mem_data_ok = 1'b0; bus.mem_rdata = '0;
        smp();
        n_checks++; if (err_timeout !== 1'b1 || stallreq !== 1'b0 || cpu_rdata !== 32'h77)
            begin n_fail++; $display("FAIL timeout_sticky: got err=%b stall=%b rdata=%h want 1/0/00000077", err_timeout, stallreq, cpu_rdata); end
        next_cyc();
        cpu_en = 1'b0;
        $display("txn load addr=00007000 late data_ok, err_timeout=%b", err_timeout);
        resetn = 1'b0;
        #1;
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_reset_clear: got %b want 0", err_timeout); end
        next_cyc();
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load();
        test_store_byte();
        test_addr_ok_delay();
        test_back_to_back();
        test_size_decode();
        test_reset_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
